// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, message-granular arbiter that shares one UART
//               transmit line among NUM_REQ byte-stream requesters and
//               serializes each accepted byte as 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 645
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         uart_tx,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [c_CNT_W-1:0]  r_baudCnt;
    logic [2:0]          r_bitIdx;
    logic [7:0]          r_shift;
    logic [c_ID_W-1:0]   r_rr;
    logic                r_lock;
    logic [c_ID_W-1:0]   r_lockId;
    logic [c_ID_W-1:0]   r_grantId;
    logic                r_tx;

    logic                w_found;
    logic [c_ID_W-1:0]   w_winner;
    logic [7:0]          w_byte;
    logic                w_baudDone;
    logic                w_accept;
    logic                w_txNext;

    assign w_baudDone = (r_baudCnt == c_CNT_W'(CLKS_PER_BIT - 1));
    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign uart_tx    = r_tx;
    assign busy       = (r_state != S_IDLE) || r_lock;
    assign grant_id   = r_grantId;

    // Pick the requester to serve: the lock owner only, else first valid from rr.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        if (r_lock) begin
            w_found  = req_valid[r_lockId];
            w_winner = r_lockId;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(r_rr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!w_found && req_valid[c_ID_W'(idx)]) begin
                    w_found  = 1'b1;
                    w_winner = c_ID_W'(idx);
                end
            end
        end
        w_byte = req_data[8*int'(w_winner) +: 8];
    end

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state, handshake and next line level (registered so the pin never glitches).
    always_comb begin
        w_stateNext = r_state;
        req_ready   = '0;
        w_txNext    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = ~rst;
                    w_stateNext         = S_START;
                    w_txNext            = 1'b0;
                end
            end
            S_START: begin
                w_txNext = 1'b0;
                if (w_baudDone) begin
                    w_stateNext = S_DATA;
                    w_txNext    = r_shift[0];
                end
            end
            S_DATA: begin
                w_txNext = r_shift[0];
                if (w_baudDone) begin
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = S_STOP;
                        w_txNext    = 1'b1;
                    end else begin
                        w_txNext = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_baudDone) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Baud timing, shift register, arbitration pointer and message lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_rr      <= '0;
            r_lock    <= 1'b0;
            r_lockId  <= '0;
            r_grantId <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_txNext;
            if ((r_state == S_IDLE) || (w_stateNext != r_state) || w_baudDone) begin
                r_baudCnt <= '0;
            end else begin
                r_baudCnt <= r_baudCnt + c_CNT_W'(1);
            end
            if (w_accept) begin
                r_shift   <= w_byte;
                r_bitIdx  <= '0;
                r_grantId <= w_winner;
                if (req_last[w_winner]) begin
                    r_lock <= 1'b0;
                    r_rr   <= (w_winner == c_ID_W'(NUM_REQ - 1)) ? '0 : w_winner + c_ID_W'(1);
                end else begin
                    r_lock   <= 1'b1;
                    r_lockId <= w_winner;
                end
            end else if ((r_state == S_DATA) && w_baudDone) begin
                r_shift  <= {1'b0, r_shift[7:1]};
                r_bitIdx <= r_bitIdx + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (NUM_REQ=4, CPB=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CPB     = 4;
    localparam int FRAME   = 10 * CPB;
    localparam int LOG_N   = 8192;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   uart_tx;
    logic                   busy;
    logic [1:0]             grant_id;

    int   cyc = 0;
    logic txLog [LOG_N];
    int   passCnt = 0;
    int   totalCnt = 0;

    // Reference model of the arbitration state.
    int   mRr;
    bit   mLock;
    int   mLockId;
    int   freeAt;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Cycle counter and per-cycle record of the serial line.
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (cyc < LOG_N) txLog[cyc] = uart_tx;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int predict(input logic [NUM_REQ-1:0] v);
        if (mLock) return v[mLockId] ? mLockId : -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(mRr + k) % NUM_REQ]) return (mRr + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic void modelAccept(input int id, input logic last);
        if (last) begin
            mLock = 1'b0;
            mRr   = (id + 1) % NUM_REQ;
        end else begin
            mLock   = 1'b1;
            mLockId = id;
        end
    endfunction

    // Expected line level for each of the FRAME cycles after a handshake.
    function automatic logic [FRAME-1:0] expFrame(input logic [7:0] d);
        logic [9:0]       bits;
        logic [FRAME-1:0] r;
        bits = {1'b1, d, 1'b0};
        for (int n = 0; n < FRAME; n++) r[n] = bits[n / CPB];
        return r;
    endfunction

    function automatic logic [FRAME-1:0] obsFrame(input int c);
        logic [FRAME-1:0] r;
        for (int n = 0; n < FRAME; n++) r[n] = (c + 1 + n < LOG_N) ? txLog[c + 1 + n] : 1'bx;
        return r;
    endfunction

    task automatic waitHs(input int budget, output int hsCyc);
        hsCyc = -1;
        for (int i = 0; i < budget && hsCyc < 0; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) hsCyc = cyc;
        end
    endtask

    task automatic stepTo(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mRr = 0; mLock = 1'b0; mLockId = 0; freeAt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h11223344;
        repeat (2) @(negedge clk);
        totalCnt++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", uart_tx); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passCnt++;
        totalCnt++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else passCnt++;
        totalCnt++; if (grant_id !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", grant_id); else passCnt++;
    endtask

    task automatic test_single_byte();
        int c, c2, p;
        doReset();
        req_valid = 4'b0001; req_data = 32'h000000A5; req_last = 4'b0001;
        waitHs(20, c);
        totalCnt++;
        if (c < 0) begin $display("FAIL single_hs: no handshake, expected req0"); return; end
        if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready); else passCnt++;
        modelAccept(0, 1'b1);
        @(negedge clk);
        totalCnt++; if (req_ready !== 4'b0000) $display("FAIL single_pulse: got %b expected 0000", req_ready); else passCnt++;
        @(posedge clk); #1 req_valid = '0; req_data = $urandom;
        stepTo(c + FRAME);
        totalCnt++; if (busy !== 1'b1) $display("FAIL single_busy_end: got %b expected 1", busy); else passCnt++;
        stepTo(c + FRAME + 1);
        totalCnt++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", busy); else passCnt++;
        totalCnt++; if (grant_id !== 2'd0) $display("FAIL single_grant: got %0d expected 0", grant_id); else passCnt++;
        totalCnt++;
        if (obsFrame(c) !== expFrame(8'hA5)) $display("FAIL single_frame: got %h expected %h", obsFrame(c), expFrame(8'hA5));
        else passCnt++;
        // rr has moved to 1, so req1 beats req0 now.
        @(posedge clk); #1 req_valid = 4'b0011; req_last = 4'b0011;
        p = predict(req_valid);
        waitHs(5, c2);
        totalCnt++;
        if (c2 < 0) $display("FAIL single_rr_hs: no handshake, expected req1");
        else if (req_ready !== 4'b0010) $display("FAIL single_rr: got %b expected 0010", req_ready);
        else passCnt++;
        modelAccept(p, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        stepTo(cyc + FRAME + 1);
    endtask

    task automatic test_round_robin();
        int c, p;
        int hsC [5];
        logic [7:0] hsD [5];
        doReset();
        req_valid = 4'b1111; req_last = 4'b1111; req_data = $urandom;
        for (int k = 0; k < 5; k++) begin
            p = predict(req_valid);
            waitHs(60, c);
            totalCnt++;
            if (c < 0) begin $display("FAIL rr_hs%0d: no handshake, expected req%0d", k, p); hsC[k] = -1; continue; end
            if (req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_order%0d: got %b expected %b", k, req_ready, 4'(1 << (k % 4)));
            else passCnt++;
            hsC[k] = c;
            hsD[k] = req_data[8*p +: 8];
            modelAccept(p, 1'b1);
            if (k > 0 && hsC[k-1] >= 0) begin
                totalCnt++;
                if (c - hsC[k-1] !== FRAME + 1) $display("FAIL rr_period%0d: got %0d expected %0d", k, c - hsC[k-1], FRAME + 1);
                else passCnt++;
            end
            @(posedge clk); #1 req_data = $urandom;
            @(negedge clk);
            totalCnt++; if (grant_id !== 2'(p)) $display("FAIL rr_grant%0d: got %0d expected %0d", k, grant_id, p); else passCnt++;
        end
        @(posedge clk); #1 req_valid = '0;
        stepTo(cyc + FRAME + 1);
        for (int k = 0; k < 5; k++) begin
            if (hsC[k] < 0) continue;
            totalCnt++;
            if (obsFrame(hsC[k]) !== expFrame(hsD[k])) $display("FAIL rr_frame%0d: got %h expected %h", k, obsFrame(hsC[k]), expFrame(hsD[k]));
            else passCnt++;
        end
    endtask

    task automatic test_message_lock();
        int c, expId;
        bit r3, leak, idle;
        int hsC [3];
        logic [7:0] msg [3];
        doReset();
        for (int b = 0; b < 3; b++) msg[b] = $urandom;
        req_valid = 4'b0100; req_last = 4'b0000; req_data[23:16] = msg[0];
        waitHs(20, c);
        totalCnt++;
        if (c < 0) begin $display("FAIL lock_hs0: no handshake, expected req2"); return; end
        if (req_ready !== 4'b0100) $display("FAIL lock_first: got %b expected 0100", req_ready); else passCnt++;
        hsC[0] = c;
        modelAccept(2, 1'b0);
        r3 = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        req_valid = {r3, 3'b011}; req_last = 4'b1011;
        req_data[7:0] = $urandom; req_data[15:8] = $urandom; req_data[31:24] = $urandom;
        for (int b = 1; b < 3; b++) begin
            leak = 1'b0; idle = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (req_ready !== 4'b0000) leak = 1'b1;
                if (busy !== 1'b1) idle = 1'b1;
            end
            totalCnt++; if (leak) $display("FAIL lock_leak%0d: got ready while locked, expected 0000", b); else passCnt++;
            totalCnt++; if (idle) $display("FAIL lock_busy%0d: got busy 0 while locked, expected 1", b); else passCnt++;
            @(posedge clk); #1;
            req_valid[2] = 1'b1; req_last[2] = (b == 2); req_data[23:16] = msg[b];
            waitHs(20, c);
            totalCnt++;
            if (c < 0) begin $display("FAIL lock_hs%0d: no handshake, expected req2", b); return; end
            if (req_ready !== 4'b0100) $display("FAIL lock_byte%0d: got %b expected 0100", b, req_ready); else passCnt++;
            hsC[b] = c;
            modelAccept(2, b == 2);
            @(posedge clk); #1 req_valid[2] = 1'b0; req_data[23:16] = $urandom;
        end
        expId = r3 ? 3 : 0;
        waitHs(60, c);
        totalCnt++;
        if (c < 0) $display("FAIL lock_next_hs: no handshake, expected req%0d", expId);
        else if (req_ready !== 4'(1 << expId)) $display("FAIL lock_next: got %b expected %b", req_ready, 4'(1 << expId));
        else passCnt++;
        modelAccept(expId, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        stepTo(cyc + FRAME + 1);
        for (int b = 0; b < 3; b++) begin
            totalCnt++;
            if (obsFrame(hsC[b]) !== expFrame(msg[b])) $display("FAIL lock_frame%0d: got %h expected %h", b, obsFrame(hsC[b]), expFrame(msg[b]));
            else passCnt++;
        end
    endtask

    task automatic test_rr_wrap();
        int c;
        doReset();
        req_valid = 4'b0100; req_last = 4'b1111; req_data = $urandom;
        waitHs(20, c);
        modelAccept(2, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        stepTo(cyc + FRAME + 1);
        @(posedge clk); #1 req_valid = 4'b0010;
        waitHs(20, c);
        totalCnt++;
        if (c < 0) $display("FAIL wrap_hs: no handshake, expected req1");
        else if (req_ready !== 4'b0010) $display("FAIL wrap_only1: got %b expected 0010", req_ready);
        else passCnt++;
        modelAccept(1, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        stepTo(cyc + FRAME + 1);
        @(posedge clk); #1 req_valid = 4'b1110;
        waitHs(20, c);
        totalCnt++;
        if (c < 0) $display("FAIL wrap_rr2_hs: no handshake, expected req2");
        else if (req_ready !== 4'b0100) $display("FAIL wrap_rr2: got %b expected 0100", req_ready);
        else passCnt++;
        modelAccept(2, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        stepTo(cyc + FRAME + 1);
    endtask

    task automatic test_reset_mid_frame();
        int c;
        logic [7:0] d;
        doReset();
        req_valid = 4'b0011; req_last = 4'b0000; req_data = 32'h0000FF00;
        waitHs(20, c);
        totalCnt++;
        if (c < 0) begin $display("FAIL mid_hs: no handshake, expected req0"); return; end
        if (req_ready !== 4'b0001) $display("FAIL mid_first: got %b expected 0001", req_ready); else passCnt++;
        stepTo(c + 1 + 4 * CPB + 1);
        totalCnt++; if (uart_tx !== 1'b0) $display("FAIL mid_bit3: got %b expected 0", uart_tx); else passCnt++;
        rst = 1'b1;
        #1;
        totalCnt++; if (uart_tx !== 1'b1) $display("FAIL mid_rst_tx: got %b expected 1", uart_tx); else passCnt++;
        totalCnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else passCnt++;
        totalCnt++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); else passCnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        mRr = 0; mLock = 1'b0; freeAt = 0;
        d = $urandom;
        req_valid = 4'b0001; req_last = 4'b0001; req_data = {24'h0, d};
        waitHs(5, c);
        totalCnt++;
        if (c < 0) begin $display("FAIL mid_after_hs: no handshake, expected req0"); return; end
        if (req_ready !== 4'b0001) $display("FAIL mid_after_ready: got %b expected 0001", req_ready); else passCnt++;
        modelAccept(0, 1'b1);
        @(posedge clk); #1 req_valid = '0; req_data = $urandom;
        stepTo(c + FRAME + 1);
        totalCnt++;
        if (obsFrame(c) !== expFrame(d)) $display("FAIL mid_after_frame: got %h expected %h", obsFrame(c), expFrame(d));
        else passCnt++;
    endtask

    task automatic test_random_traffic();
        int p, hsN;
        logic [NUM_REQ-1:0] expR;
        int pendC [$];
        logic [7:0] pendD [$];
        doReset();
        hsN = 0;
        for (int t = 0; t < 2500 && hsN < 30; t++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom);
            for (int i = 0; i < NUM_REQ; i++) req_last[i] = ($urandom_range(0, 2) == 0);
            req_data = $urandom;
            @(negedge clk);
            p = (cyc >= freeAt) ? predict(req_valid) : -1;
            expR = (p >= 0) ? 4'(1 << p) : 4'b0000;
            totalCnt++;
            if (req_ready !== expR) $display("FAIL rand_ready@%0d: got %b expected %b", cyc, req_ready, expR);
            else passCnt++;
            if (p >= 0) begin
                pendC.push_back(cyc);
                pendD.push_back(req_data[8*p +: 8]);
                modelAccept(p, req_last[p]);
                freeAt = cyc + FRAME + 1;
                hsN++;
            end
            while (pendC.size() > 0 && cyc > pendC[0] + FRAME) begin
                totalCnt++;
                if (obsFrame(pendC[0]) !== expFrame(pendD[0]))
                    $display("FAIL rand_frame@%0d: got %h expected %h", pendC[0], obsFrame(pendC[0]), expFrame(pendD[0]));
                else passCnt++;
                void'(pendC.pop_front());
                void'(pendD.pop_front());
            end
        end
        @(posedge clk); #1 req_valid = '0;
        stepTo(freeAt);
        while (pendC.size() > 0) begin
            totalCnt++;
            if (obsFrame(pendC[0]) !== expFrame(pendD[0]))
                $display("FAIL rand_frame@%0d: got %h expected %h", pendC[0], obsFrame(pendC[0]), expFrame(pendD[0]));
            else passCnt++;
            void'(pendC.pop_front());
            void'(pendD.pop_front());
        end
        totalCnt++;
        if (hsN !== 30) $display("FAIL rand_count: got %0d handshakes expected 30", hsN); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_message_lock();
        test_rr_wrap();
        test_reset_mid_frame();
        test_random_traffic();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the board's single UART transmit line between several byte-stream requesters (core console, debug/monitor, status reporters). It arbitrates round-robin at message granularity, so a multi-byte message is never interleaved with another requester's bytes. It also serializes each accepted byte as 8N1 on `uart_tx`. It sits between `CoreWrapper`-side producers and the `TxD` pin, in the pixel/system clock domain.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, default 645: clock cycles per UART bit; 74.25 MHz / 115200 ≈ 645; minimum 2.

Ports:
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ: requester i has a byte on its `req_data` slice.
- `req_data`  in  8*NUM_REQ: byte for requester i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ: the offered byte ends requester i's message.
- `req_ready`  out  NUM_REQ: one-hot or zero; a byte transfers on `req_valid[i] & req_ready[i]`.
- `uart_tx`  out  1: serial output, idle high.
- `busy`  out  1: a frame is being shifted or a message lock is held.
- `grant_id`  out  clog2(NUM_REQ): index of the last or current granted requester.

## Operation
- Frame FSM states:
  - IDLE: arbitrate and accept.
  - START: `uart_tx=0` for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: `uart_tx=1` for CLKS_PER_BIT cycles, then return to IDLE.
- Registers: baud counter (counts 0..CLKS_PER_BIT-1, cleared on every state entry), 3-bit bit index, 8-bit shift register, rr pointer, lock flag, locked id.
- Arbitration in IDLE when unlocked:
  - Eligible set is all i with `req_valid[i]`.
  - The winner is the first eligible index scanning rr, rr+1, … modulo NUM_REQ.
  - `req_ready` is asserted combinationally for the winner only.
- Arbitration in IDLE when locked:
  - Only the locked id is eligible.
  - If its valid is low, nothing is accepted, even if others are valid.
- On acceptance:
  - Load the shift register, set `grant_id` to the winner, go to START.
  - If `req_last=0`: set lock and record the locked id.
  - If `req_last=1`: clear lock and set rr to winner+1, wrapping NUM_REQ-1 → 0.
- `req_ready` is all zeros in START, DATA and STOP.
- `busy` = (state != IDLE) | lock.
- A single-byte message has `req_last=1` on its only byte.

## Timing
- Reset values:
  - `uart_tx` = 1, `req_ready` = 0, `busy` = 0, `grant_id` = 0.
  - rr = 0, lock = 0, state = IDLE.
  - Reset takes effect asynchronously, including mid-frame: the line returns high at once and any partial frame is abandoned.
- Acceptance to start bit: the start bit (`uart_tx`=0) appears on the first clock after acceptance.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- IDLE lasts at least 1 cycle, so back-to-back bytes have a period of 10·CLKS_PER_BIT+1 cycles.
- Data bit k occupies cycles [1+(1+k)·CPB, 1+(2+k)·CPB) after acceptance.
- When requester i waits for the lock held by j: i's wait is unbounded by design; j must complete its message.
- Multiple simultaneous valids are resolved only by the rr order; there are no fixed priorities.
- Inputs changing while ready=0 are ignored, and data is sampled only at the handshake.

## Test plan
(Parameters: NUM_REQ=4, CLKS_PER_BIT=4.)
1. Reset, then req0 offers 0xA5 with last=1.
   - Required: ready0 pulses 1 cycle.
   - Required: `uart_tx` sequence is 0,1,0,1,0,0,1,0,1,1 (4 cycles per bit).
   - Required: `busy` is low again 41 cycles after the handshake and rr=1.
2. All four requesters valid with last=1 continuously.
   - Required: grant order is 0,1,2,3,0 and consecutive handshakes are 41 cycles apart.
3. req2 sends a 3-byte message (last on byte 3) while req0 and req1 stay valid.
   - Required: bytes 2 and 3 are granted to req2 even if req2's valid drops for 100 cycles between bytes.
   - Required: the next grant goes to req3 if it is valid, else req0.
4. rr=3, only req1 valid → req1 is granted; rr becomes 2.
5. Assert `rst` during DATA bit 3.
   - Required: `uart_tx`=1, `busy`=0 and `req_ready`=0 immediately.
   - Required: after release, a new byte from req0 produces a clean full frame.
6. req_data changes while ready=0, mid-frame → the transmitted byte equals the value at the handshake.
